// File: rtl/ocr_pkg.sv
// ocr_pkg: glyph geometry, FSM state encoding and the 8x8 digit font shared by
// the glyph rasterizer and its ROM.
`default_nettype none

package ocr_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Each digit is eight row bytes, top row in the most significant byte.
    function automatic logic [7:0] glyph_row(input logic [3:0] digit, input logic [2:0] row);
        logic [63:0] g;
        case (digit)
            4'd0:    g = 64'h3C666E7666663C00;
            4'd1:    g = 64'h1838181818187E00;
            4'd2:    g = 64'h3C66060C30607E00;
            4'd3:    g = 64'h3C66061C06663C00;
            4'd4:    g = 64'h060E1E667F060600;
            4'd5:    g = 64'h7E607C0606663C00;
            4'd6:    g = 64'h3C66607C66663C00;
            4'd7:    g = 64'h7E660C1818181800;
            4'd8:    g = 64'h3C66663C66663C00;
            4'd9:    g = 64'h3C66663E06663C00;
            default: g = 64'h0;
        endcase
        return g[{~row, 3'b000} +: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ocr_glyph_rom.sv
// ocr_glyph_rom: glyph font ROM, address {digit,row}, one-cycle registered read.
`default_nettype none

module ocr_glyph_rom
    import ocr_pkg::*;
(
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic [6:0] addr_i,
    output logic [7:0] data_o
);

    logic [7:0] data_q;

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            data_q <= '0;
        end else begin
            data_q <= glyph_row(addr_i[6:3], addr_i[2:0]);
        end
    end

    assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/ocr_glyph_rasterizer.sv
// ocr_glyph_rasterizer: streams a digit glyph as a scaled row-major pixel raster
// with sof/eol/eof markers over a valid/ready handshake.
`default_nettype none

module ocr_glyph_rasterizer
    import ocr_pkg::*;
#(
    parameter int SCALE  = 1,
    parameter bit INVERT = 1'b0
) (
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       start_i,
    input  logic [3:0] digit_i,
    output logic       busy_o,
    output logic       err_o,
    output logic       pix_out_o,
    output logic       pix_valid_o,
    input  logic       pix_ready_i,
    output logic       sof_o,
    output logic       eol_o,
    output logic       eof_o,
    output logic       done_o
);

    localparam logic [4:0] C_COL_LAST = 5'(GLYPH_W * SCALE - 1);
    localparam logic [4:0] C_ROW_LAST = 5'(GLYPH_H * SCALE - 1);
    localparam logic [1:0] C_SUB_LAST = 2'(SCALE - 1);

    state_e     state_q, state_d;
    logic [3:0] digit_q, digit_d;
    logic       busy_q, busy_d, err_q, err_d, done_q, done_d;
    logic       valid_q, valid_d, pix_q, pix_d;
    logic       sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic [4:0] col_q, col_d, row_q, row_d;
    logic [1:0] hsub_q, hsub_d, vsub_q, vsub_d;
    logic [2:0] srow_q, srow_d;
    logic [7:0] shreg_q, shreg_d, rowbuf_q, rowbuf_d;
    logic [7:0] w_rom_data;
    logic [2:0] w_rd_row;
    logic       w_emit;

    // While sending, the ROM is always pointed one source row ahead.
    assign w_rd_row = (state_q == ST_SEND) ? srow_q + 3'd1 : 3'd0;

    ocr_glyph_rom u_rom (
        .clk_i  (clk_i),
        .clr_i  (clr_i),
        .addr_i ({digit_q, w_rd_row}),
        .data_o (w_rom_data)
    );

    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        busy_d   = busy_q;
        err_d    = 1'b0;
        done_d   = 1'b0;
        valid_d  = valid_q;
        pix_d    = pix_q;
        sof_d    = sof_q;
        eol_d    = eol_q;
        eof_d    = eof_q;
        col_d    = col_q;
        row_d    = row_q;
        hsub_d   = hsub_q;
        vsub_d   = vsub_q;
        srow_d   = srow_q;
        shreg_d  = shreg_q;
        rowbuf_d = rowbuf_q;
        w_emit   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (digit_i > 4'd9) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        digit_d = digit_i;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!valid_q) begin
                    shreg_d  = w_rom_data;
                    rowbuf_d = w_rom_data;
                    w_emit   = 1'b1;
                end else if (pix_ready_i) begin
                    if (eof_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                        pix_d   = 1'b0;
                        sof_d   = 1'b0;
                        eol_d   = 1'b0;
                        eof_d   = 1'b0;
                        col_d   = '0;
                        row_d   = '0;
                        hsub_d  = '0;
                        vsub_d  = '0;
                        srow_d  = '0;
                    end else begin
                        w_emit = 1'b1;
                        if (hsub_q == C_SUB_LAST) begin
                            hsub_d  = '0;
                            shreg_d = {shreg_q[6:0], 1'b0};
                        end else begin
                            hsub_d = hsub_q + 2'd1;
                        end
                        if (eol_q) begin
                            col_d  = '0;
                            row_d  = row_q + 5'd1;
                            hsub_d = '0;
                            // A fresh source row comes from the prefetched ROM word.
                            if (vsub_q == C_SUB_LAST) begin
                                vsub_d   = '0;
                                srow_d   = srow_q + 3'd1;
                                shreg_d  = w_rom_data;
                                rowbuf_d = w_rom_data;
                            end else begin
                                vsub_d  = vsub_q + 2'd1;
                                shreg_d = rowbuf_q;
                            end
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_emit) begin
            valid_d = 1'b1;
            pix_d   = shreg_d[7] ^ INVERT;
            sof_d   = !valid_q;
            eol_d   = (col_d == C_COL_LAST);
            eof_d   = (col_d == C_COL_LAST) && (row_d == C_ROW_LAST);
        end
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q  <= ST_IDLE;
            digit_q  <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            pix_q    <= 1'b0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            hsub_q   <= '0;
            vsub_q   <= '0;
            srow_q   <= '0;
            shreg_q  <= '0;
            rowbuf_q <= '0;
        end else begin
            state_q  <= state_d;
            digit_q  <= digit_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            pix_q    <= pix_d;
            sof_q    <= sof_d;
            eol_q    <= eol_d;
            eof_q    <= eof_d;
            col_q    <= col_d;
            row_q    <= row_d;
            hsub_q   <= hsub_d;
            vsub_q   <= vsub_d;
            srow_q   <= srow_d;
            shreg_q  <= shreg_d;
            rowbuf_q <= rowbuf_d;
        end
    end

    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign pix_out_o   = pix_q;
    assign pix_valid_o = valid_q;
    assign sof_o       = sof_q;
    assign eol_o       = eol_q;
    assign eof_o       = eof_q;
    assign done_o      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ocr_glyph_rasterizer.sv
// tb_ocr_glyph_rasterizer: drives three rasterizer instances (SCALE 1, 2 and 4/inverted)
// and compares every beat against a raster computed directly from the font table.
`default_nettype none

module tb_ocr_glyph_rasterizer;

    logic       clk = 1'b0;
    logic       clr;
    logic       start_s [3];
    logic [3:0] digit_s [3];
    logic       ready_s [3];
    logic       busy_s  [3];
    logic       err_s   [3];
    logic       pix_s   [3];
    logic       valid_s [3];
    logic       sof_s   [3];
    logic       eol_s   [3];
    logic       eof_s   [3];
    logic       done_s  [3];

    int checks = 0;
    int errors = 0;

    logic [63:0] glyph [10] = '{
        64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00,
        64'h3C66061C06663C00, 64'h060E1E667F060600, 64'h7E607C0606663C00,
        64'h3C66607C66663C00, 64'h7E660C1818181800, 64'h3C66663C66663C00,
        64'h3C66663E06663C00
    };
    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam int S   = (i == 0) ? 1 : ((i == 1) ? 2 : 4);
        localparam bit INV = (i == 2);
        ocr_glyph_rasterizer #(.SCALE(S), .INVERT(INV)) u_dut (
            .clk_i       (clk),
            .clr_i       (clr),
            .start_i     (start_s[i]),
            .digit_i     (digit_s[i]),
            .busy_o      (busy_s[i]),
            .err_o       (err_s[i]),
            .pix_out_o   (pix_s[i]),
            .pix_valid_o (valid_s[i]),
            .pix_ready_i (ready_s[i]),
            .sof_o       (sof_s[i]),
            .eol_o       (eol_s[i]),
            .eof_o       (eof_s[i]),
            .done_o      (done_s[i])
        );
    end

    function automatic int scale_of(input int u);
        return (u == 0) ? 1 : ((u == 1) ? 2 : 4);
    endfunction

    function automatic logic [7:0] outs(input int u);
        return {busy_s[u], err_s[u], pix_s[u], valid_s[u], sof_s[u], eol_s[u], eof_s[u], done_s[u]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected beats {pix,sof,eol,eof}: output pixel (r,c) shows source pixel (r/s, c/s).
    task automatic build_exp(input int d, input int s, input bit inv);
        exp_q.delete();
        for (int r = 0; r < 8 * s; r++) begin
            for (int c = 0; c < 8 * s; c++) begin
                logic [63:0] g;
                logic [7:0]  rowbits;
                logic        b;
                g       = glyph[d];
                rowbits = g[63 - 8 * (r / s) -: 8];
                b       = rowbits[7 - (c / s)] ^ inv;
                exp_q.push_back({b, (r == 0 && c == 0), (c == 8 * s - 1),
                                 (c == 8 * s - 1) && (r == 8 * s - 1)});
            end
        end
    endtask

    task automatic run_frame(input int u, input int d, input bit rnd,
                             input int abort_at, input int inj_at);
        int   n;
        int   idx;
        int   cyc;
        logic v;
        logic rdy;
        build_exp(d, scale_of(u), (u == 2));
        n = exp_q.size();
        start_s[u] = 1'b1;
        digit_s[u] = d[3:0];
        ready_s[u] = 1'b1;
        @(posedge clk); #1;
        start_s[u] = 1'b0;
        check("busy_rise", 32'(busy_s[u]), 32'd1);
        check("lat1_valid", 32'(valid_s[u]), 32'd0);
        @(posedge clk); #1;
        check("lat2_valid", 32'(valid_s[u]), 32'd0);
        @(posedge clk); #1;
        check("lat_valid", 32'(valid_s[u]), 32'd1);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 8 * n + 20) begin
            if (idx == abort_at) begin
                clr = 1'b1;
                #1;
                check("abort_outs", 32'(outs(u)), 32'd0);
                return;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ready_s[u] = rdy;
            if (idx == inj_at) begin
                start_s[u] = 1'b1;
                digit_s[u] = 4'd3;
            end
            v = valid_s[u];
            check("valid_hold", 32'(v), 32'd1);
            check($sformatf("beat%0d_d%0d_u%0d", idx, d, u),
                  32'({pix_s[u], sof_s[u], eol_s[u], eof_s[u]}), 32'(exp_q[idx]));
            @(posedge clk);
            if (v && rdy) idx++;
            #1;
            start_s[u] = 1'b0;
            cyc++;
        end
        ready_s[u] = 1'b0;
        check("frame_complete", 32'(idx), 32'(n));
        if (!rnd) check("no_bubble", 32'(cyc), 32'(n));
        check("done_pulse", 32'(done_s[u]), 32'd1);
        check("done_valid", 32'(valid_s[u]), 32'd0);
        check("done_busy", 32'(busy_s[u]), 32'd1);
        @(posedge clk); #1;
        check("done_once", 32'(done_s[u]), 32'd0);
        check("idle_busy", 32'(busy_s[u]), 32'd0);
    endtask

    initial begin
        clr = 1'b1;
        for (int u = 0; u < 3; u++) begin
            start_s[u] = 1'b1;
            digit_s[u] = 4'd5;
            ready_s[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) check("rst_outs", 32'(outs(u)), 32'd0);
        for (int u = 0; u < 3; u++) start_s[u] = 1'b0;
        clr = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            for (int u = 0; u < 3; u++) check("post_rst_outs", 32'(outs(u)), 32'd0);
        end

        run_frame(0, 1, 1'b0, -1, -1);

        start_s[0] = 1'b1;
        digit_s[0] = 4'd12;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        check("err_pulse", 32'(err_s[0]), 32'd1);
        check("err_busy", 32'(busy_s[0]), 32'd0);
        repeat (10) begin
            @(posedge clk); #1;
            check("err_after", 32'({err_s[0], busy_s[0], valid_s[0]}), 32'd0);
        end

        run_frame(0, 0, 1'b1, -1, -1);
        run_frame(1, 1, 1'b0, -1, -1);

        run_frame(0, 1, 1'b0, 20, -1);
        repeat (2) @(posedge clk);
        #1;
        check("abort_hold", 32'(outs(0)), 32'd0);
        clr = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("abort_quiet", 32'(outs(0)), 32'd0);
        end
        run_frame(0, 7, 1'b0, -1, -1);

        run_frame(0, 1, 1'b0, -1, 10);
        repeat (5) begin
            @(posedge clk); #1;
            check("inj_quiet", 32'({done_s[0], busy_s[0], valid_s[0]}), 32'd0);
        end

        for (int k = 0; k < 6; k++) begin
            run_frame(k % 3, int'($urandom_range(0, 9)), 1'b1, -1, -1);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
